// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU memory stage and mem_responder.
// master = CPU side, slave = memory side.
interface mem_responder_if;
  logic        start;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] q;
  logic        err;

  modport master (
    output start, we, addr, wdata,
    input  ready, done, q, err
  );

  modport slave (
    input  start, we, addr, wdata,
    output ready, done, q, err
  );
endinterface

// File: rtl/mem_responder.sv
// Variable-latency word memory with range checking for CPU requests.
// Optional access counters are enabled with MEM_RESP_STATS_EN.
module mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_responder_if.slave bus
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        accept;
  logic        access;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        in_range;
  logic [ADDR_BITS-1:0] idx;
  logic        unused_lsb;

  logic [31:0] mem [DEPTH];

  assign bus.ready = (state == IDLE) || (state == RESP);
  assign bus.done  = (state == RESP);
  assign accept    = bus.ready && bus.start;

  // Zero-latency builds access the live request at its accept edge.
  always_comb begin
    a_we     = NO_WAIT ? bus.we    : r_we;
    a_addr   = NO_WAIT ? bus.addr  : r_addr;
    a_wdata  = NO_WAIT ? bus.wdata : r_wdata;
    access   = NO_WAIT ? accept
                       : ((state == WAIT) && (cnt == 8'd1));
    in_range = (a_addr[31:ADDR_BITS+2] == '0);
    idx      = a_addr[ADDR_BITS+1:2];
  end

  assign unused_lsb = ^a_addr[1:0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE, RESP: begin
        if (bus.start) begin
          state_nx = NO_WAIT ? RESP : WAIT;
          cnt_nx   = WAIT_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) state_nx = RESP;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      bus.q   <= '0;
      bus.err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (access) begin
        if (in_range) begin
          bus.q   <= a_we ? a_wdata : mem[idx];
          bus.err <= 1'b0;
        end else begin
          bus.q   <= '0;
          bus.err <= 1'b1;
        end
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (access && in_range && a_we) mem[idx] <= a_wdata;
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (access && in_range) begin
      if (a_we) wr_count <= wr_count + 32'd1;
      else      rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait
// cycles and one with none; counter checks under MEM_RESP_STATS_EN.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd2, wr2, rd0, wr0;
`endif

  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .bus      (b2)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count (rd2),
    .wr_count (wr2)
`endif
  );

  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .bus      (b0)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count (rd0),
    .wr_count (wr0)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fast, input bit s, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    if (fast) begin
      b0.start = s; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.start = s; b2.we = w; b2.addr = a; b2.wdata = d;
    end
  endtask

  function automatic logic is_done(input bit fast);
    return fast ? b0.done : b2.done;
  endfunction

  function automatic logic is_ready(input bit fast);
    return fast ? b0.ready : b2.ready;
  endfunction

  function automatic logic [31:0] get_q(input bit fast);
    return fast ? b0.q : b2.q;
  endfunction

  function automatic logic get_err(input bit fast);
    return fast ? b0.err : b2.err;
  endfunction

  // One request from idle; checks latency and returns the response.
  task automatic do_req(input bit fast, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input string tag,
                        output logic [31:0] q, output logic e);
    int lat;
    int wc;
    wc = fast ? 0 : 2;
    drive(fast, 1'b1, w, a, d);
    tick();
    drive(fast, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!fast) chk({tag, ".busy"}, 32'(is_ready(fast)), 32'd0);
    lat = 0;
    while (!is_done(fast) && lat < 16) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(wc));
    q = get_q(fast);
    e = get_err(fast);
    tick();
  endtask

  logic [31:0] q;
  logic        e;
  int          n;
  int          cnt;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    chk("rst.ready",  32'(b2.ready), 32'd1);
    chk("rst.done",   32'(b2.done),  32'd0);
    chk("rst.q",      b2.q,          32'h0);
    chk("rst.err",    32'(b2.err),   32'd0);
    chk("rst.ready0", 32'(b0.ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10", q, e);
    chk("wr10.q",   q,       32'hDEADBEEF);
    chk("wr10.err", 32'(e),  32'd0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, "rd10", q, e);
    chk("rd10.q",   q,       32'hDEADBEEF);
    chk("rd10.err", 32'(e),  32'd0);
    chk("hold.q",   b2.q,    32'hDEADBEEF);

    do_req(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, "wr0", q, e);
    do_req(1'b0, 1'b0, 32'h00100000, 32'h0, "oor.rd", q, e);
    chk("oor.rd.q",   q,      32'h0);
    chk("oor.rd.err", 32'(e), 32'd1);
    do_req(1'b0, 1'b1, 32'h00001000, 32'h1234, "oor.wr", q, e);
    chk("oor.wr.q",   q,      32'h0);
    chk("oor.wr.err", 32'(e), 32'd1);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, "rd0", q, e);
    chk("rd0.q",   q,      32'hA5A5A5A5);
    chk("rd0.err", 32'(e), 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hC0DE0000 + 32'(i),
             "b2b.wr", q, e);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n = 1;
      while (!b0.done && n < 8) begin
        tick();
        n++;
      end
      chk("b2b.done", 32'(b0.done), 32'd1);
      chk("b2b.q",    b0.q,         32'hC0DE0000 + 32'(i));
      if (i < 3) drive(1'b1, 1'b1, 1'b0, 32'h44 + 32'(4 * i), 32'h0);
      else       drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    tick();

    do_req(1'b0, 1'b1, 32'h20, 32'h20202020, "wr20", q, e);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h00000BAD);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cnt = 0;
    repeat (6) begin
      if (b2.done) begin
        cnt++;
        chk("ign.q", b2.q, 32'hDEADBEEF);
      end
      tick();
    end
    chk("ign.dones", 32'(cnt), 32'd1);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, "rd20", q, e);
    chk("rd20.q", q, 32'h20202020);

    do_req(1'b0, 1'b1, 32'h8, 32'h11111111, "wr8", q, e);
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h55);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    chk("mid.ready", 32'(b2.ready), 32'd1);
    chk("mid.done",  32'(b2.done),  32'd0);
    #2;
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (b2.done) cnt++;
    end
    chk("mid.dones", 32'(cnt), 32'd0);
    do_req(1'b0, 1'b0, 32'h8, 32'h0, "rd8", q, e);
    chk("rd8.q", q, 32'h11111111);

`ifdef MEM_RESP_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    do_req(1'b0, 1'b0, 32'h10, 32'h0, "st.r1", q, e);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, "st.r2", q, e);
    do_req(1'b0, 1'b1, 32'h30, 32'h3, "st.w1", q, e);
    do_req(1'b0, 1'b0, 32'h00100000, 32'h0, "st.oor", q, e);
    do_req(1'b0, 1'b1, 32'h34, 32'h4, "st.w2", q, e);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, "st.r3", q, e);
    chk("st.rd", rd2, 32'd3);
    chk("st.wr", wr2, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("st.rd.rst", rd2, 32'd0);
    chk("st.wr.rst", wr2, 32'd0);
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
